// File: rtl/alu_seq_arbiter.sv
// Round-robin arbiter sharing one start/done sequential ALU between two requesters.
// Optional WAIT watchdog enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_seq_arbiter #(
  parameter int DW             = 32,
  parameter int CW             = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [CW-1:0] req0_ctrl,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [CW-1:0] req1_ctrl,
  output logic          unit_start,
  output logic [DW-1:0] unit_a,
  output logic [DW-1:0] unit_b,
  output logic [CW-1:0] unit_ctrl,
  input  logic          unit_done,
  input  logic [DW-1:0] unit_result,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    r_state;
  logic          r_last_grant;
  logic          r_rsp_id;
  logic          r_rsp_err;
  logic [DW-1:0] r_unit_a;
  logic [DW-1:0] r_unit_b;
  logic [CW-1:0] r_unit_ctrl;
  logic [DW-1:0] r_rsp_data;

  logic w_grant;
  logic w_idle;
  logic w_accept;
  logic w_timeout;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    w_grant = req1_valid;
    if (req0_valid && req1_valid) w_grant = ~r_last_grant;
  end

  // Readies are gated by rst so they read 0 while reset is held.
  assign w_idle     = (r_state == S_IDLE) && !rst;
  assign w_accept   = w_idle && (req0_valid || req1_valid);
  assign req0_ready = w_idle && req0_valid && !w_grant;
  assign req1_ready = w_idle && req1_valid && w_grant;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Fires in the last permitted WAIT cycle; unit_done in that cycle still wins.
  assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog compiled out: the comparison is never true.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_rsp_id     <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_unit_a     <= '0;
      r_unit_b     <= '0;
      r_unit_ctrl  <= '0;
      r_rsp_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_unit_a     <= w_grant ? req1_a    : req0_a;
            r_unit_b     <= w_grant ? req1_b    : req0_b;
            r_unit_ctrl  <= w_grant ? req1_ctrl : req0_ctrl;
            r_rsp_id     <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (unit_done) begin
            r_rsp_data <= unit_result;
            r_rsp_err  <= 1'b0;
            r_state    <= S_RESP;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign unit_start = (r_state == S_ISSUE);
  assign unit_a     = r_unit_a;
  assign unit_b     = r_unit_b;
  assign unit_ctrl  = r_unit_ctrl;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_seq_arbiter.sv
// Self-checking bench for alu_seq_arbiter; unit model and scoreboard live here.
module tb_alu_seq_arbiter;
  localparam int DW = 32;
  localparam int CW = 5;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [CW-1:0] req0_ctrl, req1_ctrl;
  logic          unit_start, unit_done;
  logic [DW-1:0] unit_a, unit_b, unit_result;
  logic [CW-1:0] unit_ctrl;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [DW-1:0] rsp_data;

  int nvec = 0;
  int nerr = 0;

  alu_seq_arbiter #(.DW(DW), .CW(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b), .unit_ctrl(unit_ctrl),
    .unit_done(unit_done), .unit_result(unit_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  wire [106:0] all_out = {req0_ready, req1_ready, unit_start, unit_a, unit_b, unit_ctrl,
                          rsp_valid, rsp_id, rsp_data, rsp_err};

  // Behaviour of the shared unit: opcode low bits select add/sub/and/xor.
  function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [CW-1:0] c);
    case (c[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsp_ready = 0; unit_done = 0; unit_result = '0;
    req0_a = '0; req0_b = '0; req0_ctrl = '0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; req0_valid = 1; req1_valid = 1;
    @(negedge clk); #1;
    nvec++; if (all_out !== '0) begin nerr++; $display("FAIL reset_hold got %h want 0", all_out); end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk); rst = 0; #1;
    nvec++; if (all_out !== '0) begin nerr++; $display("FAIL reset_release got %h want 0", all_out); end
  endtask

  task automatic test_single();
    int start_c = -1, done_c = -1, rsp_c = -1, rdy_n = 0, st_n = 0;
    logic [DW-1:0] ga = '0, gb = '0, gdata = '0;
    logic [CW-1:0] gc = '0;
    logic gid = 1'b1, gerr = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin req0_valid = 1; req0_a = 5; req0_b = 3; req0_ctrl = 0; end
      unit_done = (start_c >= 0) && (c == start_c + 4);
      unit_result = unit_done ? 32'd8 : 32'hDEAD_BEEF;
      if (unit_done) done_c = c;
      #1;
      if (req0_ready) rdy_n++;
      if (unit_start) begin
        st_n++;
        if (start_c < 0) begin start_c = c; ga = unit_a; gb = unit_b; gc = unit_ctrl; end
      end
      if (rsp_valid && rsp_c < 0) begin rsp_c = c; gid = rsp_id; gdata = rsp_data; gerr = rsp_err; end
    end
    nvec++; if (rdy_n !== 1) begin nerr++; $display("FAIL single_ready_pulses got %0d want 1", rdy_n); end
    nvec++; if (st_n !== 1) begin nerr++; $display("FAIL single_start_pulses got %0d want 1", st_n); end
    nvec++; if (start_c !== 1) begin nerr++; $display("FAIL single_start_cycle got %0d want 1", start_c); end
    nvec++; if ({ga, gb, gc} !== {32'd5, 32'd3, 5'd0}) begin nerr++; $display("FAIL single_unit_ops got %0d/%0d/%0d want 5/3/0", ga, gb, gc); end
    nvec++; if (rsp_c !== done_c + 1) begin nerr++; $display("FAIL single_rsp_cycle got %0d want %0d", rsp_c, done_c + 1); end
    nvec++; if ({gid, gerr, gdata} !== {1'b0, 1'b0, 32'd8}) begin nerr++; $display("FAIL single_rsp got id=%0d err=%0d data=%0d want 0/0/8", gid, gerr, gdata); end
    @(negedge clk); req0_valid = 0; rsp_ready = 1; unit_done = 0;
    @(negedge clk); rsp_ready = 0; #1;
    nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL single_back_idle got %b want 0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_d;
    @(negedge clk);
    req0_valid = 1; req0_a = $urandom; req0_b = $urandom; req0_ctrl = CW'($urandom);
    exp_d = ref_alu(req0_a, req0_b, req0_ctrl); #1;
    nvec++; if (req0_ready !== 1'b1) begin nerr++; $display("FAIL bp_accept got %b want 1", req0_ready); end
    @(negedge clk); req0_valid = 0; #1;
    nvec++; if (unit_start !== 1'b1) begin nerr++; $display("FAIL bp_start got %b want 1", unit_start); end
    @(negedge clk); unit_done = 1; unit_result = ref_alu(unit_a, unit_b, unit_ctrl);
    @(negedge clk); unit_done = 0; unit_result = $urandom;
    req1_valid = 1; req1_a = $urandom; req1_b = $urandom; req1_ctrl = CW'($urandom);
    for (int i = 0; i < 10; i++) begin
      #1;
      nvec++; if ({rsp_valid, req1_ready, unit_start, rsp_id} !== 4'b1000) begin
        nerr++; $display("FAIL bp_hold_ctrl i=%0d got %b want 1000", i, {rsp_valid, req1_ready, unit_start, rsp_id}); end
      nvec++; if (rsp_data !== exp_d) begin nerr++; $display("FAIL bp_hold_data i=%0d got %h want %h", i, rsp_data, exp_d); end
      @(negedge clk);
    end
    req1_valid = 0; rsp_ready = 1;
    @(negedge clk); rsp_ready = 0; #1;
    nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL bp_release got %b want 0", rsp_valid); end
  endtask

  task automatic test_spurious();
    logic [DW-1:0] good;
    @(negedge clk);
    req1_valid = 1; req1_a = $urandom; req1_b = $urandom; req1_ctrl = CW'($urandom);
    good = ref_alu(req1_a, req1_b, req1_ctrl); #1;
    nvec++; if ({req0_ready, req1_ready} !== 2'b01) begin nerr++; $display("FAIL spur_accept got %b want 01", {req0_ready, req1_ready}); end
    @(negedge clk); req1_valid = 0; unit_done = 1; unit_result = ~good; #1;
    nvec++; if (unit_start !== 1'b1) begin nerr++; $display("FAIL spur_start got %b want 1", unit_start); end
    @(negedge clk); unit_done = 0; #1;
    nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL spur_early_rsp got %b want 0", rsp_valid); end
    @(negedge clk);
    @(negedge clk); unit_done = 1; unit_result = ref_alu(unit_a, unit_b, unit_ctrl);
    @(negedge clk); unit_done = 0; #1;
    nvec++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b110) begin nerr++; $display("FAIL spur_rsp_ctrl got %b want 110", {rsp_valid, rsp_id, rsp_err}); end
    nvec++; if (rsp_data !== good) begin nerr++; $display("FAIL spur_rsp_data got %h want %h", rsp_data, good); end
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
  endtask

  task automatic test_reset_midflight();
    @(negedge clk); req0_valid = 1; req0_a = $urandom; req0_b = $urandom; req0_ctrl = CW'($urandom);
    @(negedge clk); req0_valid = 0;
    @(negedge clk);
    @(negedge clk); rst = 1; #1;
    nvec++; if (all_out !== '0) begin nerr++; $display("FAIL rstmid_async got %h want 0", all_out); end
    @(negedge clk); rst = 0; unit_done = 1; unit_result = $urandom | 32'h1; #1;
    nvec++; if (all_out !== '0) begin nerr++; $display("FAIL rstmid_idle got %h want 0", all_out); end
    @(negedge clk); unit_done = 0; #1;
    nvec++; if (all_out !== '0) begin nerr++; $display("FAIL rstmid_late_done got %h want 0", all_out); end
    req0_valid = 1; req1_valid = 1; #1;
    nvec++; if ({req0_ready, req1_ready} !== 2'b10) begin nerr++; $display("FAIL rstmid_tie got %b want 10", {req0_ready, req1_ready}); end
    rst = 1; req0_valid = 0; req1_valid = 0;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_timeout();
    logic [DW-1:0] good, exp_d;
    logic exp_e;
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      req0_valid = 1; req0_a = $urandom; req0_b = $urandom; req0_ctrl = CW'($urandom);
      good = ref_alu(req0_a, req0_b, req0_ctrl);
      for (int k = 1; k <= TO + 1; k++) begin
        @(negedge clk);
        req0_valid = 0;
        unit_done = (v == 1) && (k == TO + 1);
        unit_result = unit_done ? ref_alu(unit_a, unit_b, unit_ctrl) : $urandom;
      end
      #1;
      nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL to_wait v=%0d got %b want 0", v, rsp_valid); end
      @(negedge clk); unit_done = 0;
`ifdef ALU_ARB_TIMEOUT_EN
      exp_e = (v == 0);
      exp_d = (v == 0) ? '0 : good;
`else
      exp_e = 1'b0;
      exp_d = good;
      if (v == 0) begin
        repeat (20) @(negedge clk);
        #1;
        nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL to_no_watchdog got %b want 0", rsp_valid); end
        unit_done = 1; unit_result = ref_alu(unit_a, unit_b, unit_ctrl);
        @(negedge clk); unit_done = 0;
      end
`endif
      #1;
      nvec++; if ({rsp_valid, rsp_err} !== {1'b1, exp_e}) begin nerr++; $display("FAIL to_rsp_ctrl v=%0d got %b want %b", v, {rsp_valid, rsp_err}, {1'b1, exp_e}); end
      nvec++; if (rsp_data !== exp_d) begin nerr++; $display("FAIL to_rsp_data v=%0d got %h want %h", v, rsp_data, exp_d); end
      rsp_ready = 1;
      @(negedge clk); rsp_ready = 0;
    end
  endtask

  // Transaction-level model: grant rule, busy from accept to response handshake,
  // start one cycle after accept, response the cycle after the unit's done.
  task automatic test_traffic(input int nops, input bit both, input bit stall);
    logic last, busy, g, v0, v1, eid, prev_id, exp_st, exp_rv;
    int acc_c, done_at, nresp;
    logic [DW-1:0] ea, eb, edata, res;
    logic [CW-1:0] ec;
    last = 1; busy = 0; prev_id = 1; eid = 0; acc_c = -10; done_at = -1; nresp = 0;
    ea = '0; eb = '0; ec = '0; edata = '0; res = '0;
    @(negedge clk); idle_inputs(); rst = 1;
    @(negedge clk); rst = 0;
    for (int c = 0; c < nops * 20 && nresp < nops; c++) begin
      @(negedge clk);
      v0 = both ? 1'b1 : 1'($urandom_range(0, 1));
      v1 = both ? 1'b1 : 1'($urandom_range(0, 1));
      req0_valid = v0; req0_a = $urandom; req0_b = $urandom; req0_ctrl = CW'($urandom);
      req1_valid = v1; req1_a = $urandom; req1_b = $urandom; req1_ctrl = CW'($urandom);
      rsp_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      unit_result = $urandom;
      if (busy && done_at >= 0 && c == done_at) begin
        unit_done = 1; unit_result = res;
      end else if (busy && c >= acc_c + 2 && c <= done_at) unit_done = 0;
      else unit_done = ($urandom_range(0, 3) == 0);
      #1;
      g = (v0 && v1) ? ~last : v1;
      nvec++; if ({req0_ready, req1_ready} !== {!busy && v0 && !g, !busy && v1 && g}) begin
        nerr++; $display("FAIL traffic_ready c=%0d got %b want %b", c, {req0_ready, req1_ready}, {!busy && v0 && !g, !busy && v1 && g}); end
      exp_st = busy && (c == acc_c + 1);
      nvec++; if (unit_start !== exp_st) begin nerr++; $display("FAIL traffic_start c=%0d got %b want %b", c, unit_start, exp_st); end
      exp_rv = busy && done_at >= 0 && c > done_at;
      nvec++; if (rsp_valid !== exp_rv) begin nerr++; $display("FAIL traffic_rsp_valid c=%0d got %b want %b", c, rsp_valid, exp_rv); end
      if (exp_st) begin
        nvec++; if ({unit_a, unit_b, unit_ctrl} !== {ea, eb, ec}) begin
          nerr++; $display("FAIL traffic_unit_ops c=%0d got %h/%h/%h want %h/%h/%h", c, unit_a, unit_b, unit_ctrl, ea, eb, ec); end
        done_at = c + $urandom_range(1, 5);
        res = ref_alu(unit_a, unit_b, unit_ctrl);
      end
      if (exp_rv) begin
        nvec++; if ({rsp_id, rsp_err} !== {eid, 1'b0}) begin nerr++; $display("FAIL traffic_rsp_id c=%0d got %b want %b", c, {rsp_id, rsp_err}, {eid, 1'b0}); end
        nvec++; if (rsp_data !== edata) begin nerr++; $display("FAIL traffic_rsp_data c=%0d got %h want %h", c, rsp_data, edata); end
        if (rsp_ready) begin
          if (both) begin
            nvec++; if (rsp_id !== ~prev_id) begin nerr++; $display("FAIL traffic_alternate c=%0d got %b want %b", c, rsp_id, ~prev_id); end
            prev_id = rsp_id;
          end
          busy = 0; done_at = -1; nresp++;
        end
      end else if (!busy && (v0 || v1)) begin
        busy = 1; acc_c = c; eid = g; last = g;
        ea = g ? req1_a : req0_a; eb = g ? req1_b : req0_b; ec = g ? req1_ctrl : req0_ctrl;
        edata = ref_alu(ea, eb, ec);
      end
    end
    nvec++; if (nresp !== nops) begin nerr++; $display("FAIL traffic_completed got %0d want %0d", nresp, nops); end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_spurious();
    test_reset_midflight();
    test_timeout();
    test_traffic(8, 1'b1, 1'b0);
    test_traffic(40, 1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/alu_seq_arbiter.md
# alu_seq_arbiter

Shares one multi-cycle sequential ALU unit (sequential adder, shifter or other start/done unit) between two requesters. Accepts one operation at a time through a valid/ready handshake and arbitrates round-robin between the requesters. Issues a one-cycle start to the unit, captures the result on the unit's done pulse, and returns it tagged with the requester ID. Sits between the issue logic and the sequential ALU datapath.

## Interface
- `DW`, 32, operand/result width
- `CW`, 5, ALU control (opcode) width
- `TIMEOUT_CYCLES`, 64, watchdog limit in WAIT, in cycles (used only with `ALU_ARB_TIMEOUT_EN`)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req0_valid`, `req1_valid`  in  1  request present
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle
- `req0_a`, `req1_a`  in  DW  operand A
- `req0_b`, `req1_b`  in  DW  operand B
- `req0_ctrl`, `req1_ctrl`  in  CW  operation select
- `unit_start`  out  1  one-cycle launch pulse to the ALU unit
- `unit_a`, `unit_b`  out  DW  registered operands to the unit
- `unit_ctrl`  out  CW  registered opcode to the unit
- `unit_done`  in  1  unit result valid (pulse)
- `unit_result`  in  DW  unit result
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer takes response
- `rsp_id`  out  1  requester that issued the operation
- `rsp_data`  out  DW  result
- `rsp_err`  out  1  timeout flag (tied 0 without `ALU_ARB_TIMEOUT_EN`)

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant is combinational from the valids. If only one requester is valid, it wins. If both are valid, the requester not in `last_grant` wins. `reqN_ready` = (state==IDLE) && valid && granted. On handshake: latch a/b/ctrl into `unit_*`, latch ID, update `last_grant`, go to ISSUE.
- ISSUE: `unit_start`=1 for exactly this cycle, then go to WAIT.
- WAIT: on `unit_done`, capture `unit_result` into `rsp_data`, set `rsp_err`=0, go to RESP. `unit_done` is ignored in every other state.
- RESP: `rsp_valid`=1. `rsp_id`, `rsp_data` and `rsp_err` are held stable until `rsp_ready`. On `rsp_valid && rsp_ready`, go to IDLE.
- No request is accepted outside IDLE. Both ready signals are 0 in ISSUE, WAIT and RESP.
- `unit_a`, `unit_b` and `unit_ctrl` hold their value from issue until the next accept.
- Reset (async, any state): state=IDLE, `last_grant`=1 (req0 wins the first tie). All outputs are 0: `unit_start`, `unit_a`, `unit_b`, `unit_ctrl`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_err`, both readys. Any in-flight operation is discarded, and a later `unit_done` from it is ignored in IDLE.

## Timing
- Accept at cycle T. `unit_start` is high at T+1. WAIT begins at T+2.
- `unit_done` sampled at cycle D ≥ T+2 gives `rsp_valid` high at D+1.
- Minimum accept-to-response: 3 cycles, plus the unit latency.
- Back-to-back: if the response handshakes at cycle R, state is IDLE at R+1 and the next accept can occur at R+1.
- `unit_done` coincident with reset is lost.

## Configuration
- `ALU_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each cycle spent in WAIT.
  - If it reaches `TIMEOUT_CYCLES` without `unit_done`, go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - `unit_done` in the same cycle as the limit takes priority: normal result, `rsp_err`=0.
- `ALU_ARB_TIMEOUT_EN` undefined: no counter, WAIT persists until `unit_done`, and `rsp_err` is constant 0.

## Test plan
- Reset, then hold `req0_valid` with a=5, b=3, ctrl=add; unit model returns 8 after 4 cycles -> `req0_ready` pulses once, `unit_start` is high 1 cycle, `rsp_valid`/`rsp_id`=0/`rsp_data`=8 appear at done+1.
- Both requesters valid continuously, `rsp_ready`=1 -> grants alternate 0,1,0,1, and each response `rsp_id` matches its grant order.
- Hold `rsp_ready`=0 for 10 cycles in RESP while `req1_valid`=1 -> `rsp_data` is stable, `req1_ready` stays 0, `unit_start` stays 0.
- Assert `rst` during WAIT, then pulse `unit_done` in IDLE -> all outputs are 0, no `rsp_valid`, and the next tie grants req0.
- With `ALU_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, unit never done -> `rsp_valid` with `rsp_err`=1, `rsp_data`=0 after 8 WAIT cycles. Repeat with `unit_done` on exactly the 8th cycle -> `rsp_err`=0 and the real result.
- Spurious `unit_done` during ISSUE followed by a real one 3 cycles later -> the response carries the later `unit_result`.
